// File: rtl/lsu_mem_pkg.sv
// Shared types, access-size encodings and lane helpers for the LSU-to-memory bridge.
package lsu_mem_pkg;

   localparam int XLEN = 64;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      CAPT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;
   localparam logic [1:0] SZ_D = 2'd3;

   // Unshifted byte-lane mask for an access of the given size.
   function automatic logic [7:0] lane_base(input logic [1:0] size);
      logic [7:0] base;
      case (size)
         SZ_B:    base = 8'h01;
         SZ_H:    base = 8'h03;
         SZ_W:    base = 8'h0F;
         SZ_D:    base = 8'hFF;
         default: base = 8'h00;
      endcase
      return base;
   endfunction

   // True when the byte address is not a multiple of the access size.
   function automatic logic is_misaligned(input logic [2:0] off, input logic [1:0] size);
      logic mis;
      case (size)
         SZ_B:    mis = 1'b0;
         SZ_H:    mis = (off[0] != 1'b0);
         SZ_W:    mis = (off[1:0] != 2'b00);
         SZ_D:    mis = (off != 3'b000);
         default: mis = 1'b1;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/lsu_mem_align.sv
// Combinational lane shaping: store data/mask placement and load data extraction with extension.
module lsu_mem_align
   import lsu_mem_pkg::*;
(
   input  logic [XLEN-1:0] wdata,
   input  logic [1:0]      size,
   input  logic [2:0]      off,
   input  logic [XLEN-1:0] rdata,
   input  logic            sgn,
   output logic [XLEN-1:0] wdata_lane,
   output logic [7:0]      wmask,
   output logic [XLEN-1:0] rdata_ext
);

   logic [XLEN-1:0] shifted_s;

   assign wdata_lane = wdata << {off, 3'b000};
   assign wmask      = lane_base(size) << off;
   assign shifted_s  = rdata >> {off, 3'b000};

   // Keep the accessed low bytes and extend to full width.
   always_comb begin
      rdata_ext = {XLEN{1'b0}};
      case (size)
         SZ_B: begin
            if (sgn) rdata_ext = {{56{shifted_s[7]}}, shifted_s[7:0]};
            else     rdata_ext = {56'd0, shifted_s[7:0]};
         end
         SZ_H: begin
            if (sgn) rdata_ext = {{48{shifted_s[15]}}, shifted_s[15:0]};
            else     rdata_ext = {48'd0, shifted_s[15:0]};
         end
         SZ_W: begin
            if (sgn) rdata_ext = {{32{shifted_s[31]}}, shifted_s[31:0]};
            else     rdata_ext = {32'd0, shifted_s[31:0]};
         end
         SZ_D:    rdata_ext = shifted_s;
         default: rdata_ext = {XLEN{1'b0}};
      endcase
   end

endmodule

// File: rtl/lsu_mem_bridge.sv
// Single-outstanding LSU request bridge to the physical memory model; one strobe per access,
// misaligned requests answered with an error and no memory activity.
module lsu_mem_bridge
   import lsu_mem_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_wen,
   input  logic [XLEN-1:0] req_addr,
   input  logic [XLEN-1:0] req_wdata,
   input  logic [1:0]      req_size,
   input  logic            req_signed,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic [XLEN-1:0] resp_rdata,
   output logic            resp_err,
   output logic            mem_valid,
   output logic            mem_wen,
   output logic [XLEN-1:0] mem_raddr,
   output logic [XLEN-1:0] mem_waddr,
   output logic [XLEN-1:0] mem_wdata,
   output logic [7:0]      mem_wmask,
   input  logic [XLEN-1:0] mem_rdata
);

   state_t          state_r, state_next_s;
   logic            wen_r, signed_r;
   logic [2:0]      off_r;
   logic [1:0]      size_r;
   logic            accept_s, misalign_s, issue_s;
   logic [2:0]      al_off_s;
   logic [1:0]      al_size_s;
   logic [XLEN-1:0] al_wdata_s, al_rdata_s, mem_addr_s;
   logic [7:0]      al_wmask_s;

   assign accept_s   = (state_r == IDLE) && req_valid;
   assign misalign_s = is_misaligned(req_addr[2:0], req_size);
   assign issue_s    = (state_next_s == ISSUE);
   assign mem_addr_s = {req_addr[XLEN-1:3], 3'b000};

   // Store shaping happens on the live request in IDLE; load extraction uses the latched one in CAPT.
   assign al_off_s  = (state_r == IDLE) ? req_addr[2:0] : off_r;
   assign al_size_s = (state_r == IDLE) ? req_size      : size_r;

   lsu_mem_align u_align (
      .wdata      (req_wdata),
      .size       (al_size_s),
      .off        (al_off_s),
      .rdata      (mem_rdata),
      .sgn        (signed_r),
      .wdata_lane (al_wdata_s),
      .wmask      (al_wmask_s),
      .rdata_ext  (al_rdata_s)
   );

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_r <= IDLE;
      else       state_r <= state_next_s;
   end

   // Next-state logic.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (req_valid) begin
               if (misalign_s) state_next_s = RESP;
               else            state_next_s = ISSUE;
            end else begin
               state_next_s = IDLE;
            end
         end
         ISSUE: begin
            if (wen_r) state_next_s = RESP;
            else       state_next_s = CAPT;
         end
         CAPT: state_next_s = RESP;
         RESP: begin
            if (resp_ready) state_next_s = IDLE;
            else            state_next_s = RESP;
         end
         default: state_next_s = IDLE;
      endcase
   end

   // Request latch, held for the whole transaction.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wen_r    <= 1'b0;
         signed_r <= 1'b0;
         off_r    <= 3'd0;
         size_r   <= 2'd0;
      end else if (accept_s) begin
         wen_r    <= req_wen;
         signed_r <= req_signed;
         off_r    <= req_addr[2:0];
         size_r   <= req_size;
      end else begin
         wen_r    <= wen_r;
         signed_r <= signed_r;
         off_r    <= off_r;
         size_r   <= size_r;
      end
   end

   // Registered outputs, decoded from the next state so they line up with the state they belong to.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_rdata <= {XLEN{1'b0}};
         resp_err   <= 1'b0;
         mem_valid  <= 1'b0;
         mem_wen    <= 1'b0;
         mem_raddr  <= {XLEN{1'b0}};
         mem_waddr  <= {XLEN{1'b0}};
         mem_wdata  <= {XLEN{1'b0}};
         mem_wmask  <= 8'h00;
      end else begin
         req_ready  <= (state_next_s == IDLE);
         resp_valid <= (state_next_s == RESP);
         mem_valid  <= issue_s;
         mem_wen    <= issue_s && req_wen;
         mem_raddr  <= issue_s ? mem_addr_s : {XLEN{1'b0}};
         mem_waddr  <= issue_s ? mem_addr_s : {XLEN{1'b0}};
         mem_wdata  <= (issue_s && req_wen) ? al_wdata_s : {XLEN{1'b0}};
         mem_wmask  <= (issue_s && req_wen) ? al_wmask_s : 8'h00;
         // mem_rdata is only meaningful in CAPT; the model zeroes it afterwards.
         if (accept_s) begin
            resp_rdata <= {XLEN{1'b0}};
            resp_err   <= misalign_s;
         end else if (state_r == CAPT) begin
            resp_rdata <= al_rdata_s;
            resp_err   <= resp_err;
         end else begin
            resp_rdata <= resp_rdata;
            resp_err   <= resp_err;
         end
      end
   end

endmodule

// File: tb/tb_lsu_mem_bridge.sv
// Scoreboard bench for lsu_mem_bridge: directed requests push expected memory strobes and responses.
module tb_lsu_mem_bridge;
   import lsu_mem_pkg::*;

   logic            clk = 1'b0;
   logic            reset;
   logic            req_valid, req_ready, req_wen, req_signed;
   logic [63:0]     req_addr, req_wdata;
   logic [1:0]      req_size;
   logic            resp_valid, resp_ready, resp_err;
   logic [63:0]     resp_rdata;
   logic            mem_valid, mem_wen;
   logic [63:0]     mem_raddr, mem_waddr, mem_wdata, mem_rdata;
   logic [7:0]      mem_wmask;
   logic [63:0]     mem_word;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   typedef struct {
      logic [63:0] rdata;
      logic        err;
      int          cyc;
   } resp_t;

   typedef struct {
      logic [63:0] addr;
      logic        wen;
      logic [7:0]  wmask;
      logic [63:0] wdata;
      int          cyc;
   } memx_t;

   resp_t resp_q[$];
   memx_t mem_q[$];
   resp_t r_exp;
   memx_t m_exp;
   logic        seen = 1'b0;
   logic [63:0] hold_rdata;
   logic        hold_err;

   lsu_mem_bridge dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_wen    (req_wen),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_size   (req_size),
      .req_signed (req_signed),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .mem_valid  (mem_valid),
      .mem_wen    (mem_wen),
      .mem_raddr  (mem_raddr),
      .mem_waddr  (mem_waddr),
      .mem_wdata  (mem_wdata),
      .mem_wmask  (mem_wmask),
      .mem_rdata  (mem_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Memory model: read data appears the cycle after a load strobe, zero otherwise.
   always @(posedge clk or posedge reset) begin
      if (reset) mem_rdata <= 64'd0;
      else       mem_rdata <= (mem_valid && !mem_wen) ? mem_word : 64'd0;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: memory strobes and responses compared against the queues.
   always @(negedge clk) begin
      if (!reset && mem_valid) begin
         if (mem_q.size() == 0) begin
            chk("mem_unexpected_strobe", {63'd0, mem_valid}, 64'd0);
         end else begin
            m_exp = mem_q.pop_front();
            chk("mem_raddr", mem_raddr, m_exp.addr);
            chk("mem_waddr", mem_waddr, m_exp.addr);
            chk("mem_wen",   {63'd0, mem_wen}, {63'd0, m_exp.wen});
            chk("mem_wmask", {56'd0, mem_wmask}, {56'd0, m_exp.wmask});
            chk("mem_wdata", mem_wdata, m_exp.wdata);
            chk("mem_cycle", 64'(cyc), 64'(m_exp.cyc));
         end
      end
      if (!reset && resp_valid) begin
         chk("resp_req_ready_low", {63'd0, req_ready}, 64'd0);
         chk("resp_mem_valid_low", {63'd0, mem_valid}, 64'd0);
         if (!seen) begin
            seen       = 1'b1;
            hold_rdata = resp_rdata;
            hold_err   = resp_err;
            if (resp_q.size() == 0) chk("resp_unexpected", {63'd0, resp_valid}, 64'd0);
            else                    chk("resp_cycle", 64'(cyc), 64'(resp_q[0].cyc));
         end else begin
            chk("resp_rdata_stable", resp_rdata, hold_rdata);
            chk("resp_err_stable", {63'd0, resp_err}, {63'd0, hold_err});
         end
         if (resp_ready) begin
            seen = 1'b0;
            if (resp_q.size() > 0) begin
               r_exp = resp_q.pop_front();
               chk("resp_rdata", resp_rdata, r_exp.rdata);
               chk("resp_err", {63'd0, resp_err}, {63'd0, r_exp.err});
            end
         end
      end
   end

   task automatic wait_idle();
      int n = 0;
      while (!(req_ready && !resp_valid && resp_q.size() == 0) && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 50) begin
         chk("timeout_resp_pending", 64'(resp_q.size()), 64'd0);
         chk("timeout_req_ready", {63'd0, req_ready}, 64'd1);
      end
   endtask

   // Issue one request from IDLE; expected latency counts from the accept edge as cycle 0.
   task automatic issue(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [1:0] size, input logic sgn, input logic [63:0] word,
                        input bit exp_mem, input logic [7:0] exp_mask, input logic [63:0] exp_wdata,
                        input bit exp_resp, input int lat, input logic [63:0] exp_rdata,
                        input logic exp_err);
      int a;
      mem_word   = word;
      req_wen    = wen;
      req_addr   = addr;
      req_wdata  = wdata;
      req_size   = size;
      req_signed = sgn;
      req_valid  = 1'b1;
      @(posedge clk); #1;
      req_valid  = 1'b0;
      a = cyc;
      if (exp_mem)  mem_q.push_back('{addr & ~64'd7, wen, exp_mask, exp_wdata, a});
      if (exp_resp) resp_q.push_back('{exp_rdata, exp_err, a + lat - 1});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_addr = 64'd0; req_wdata = 64'd0;
      req_size = 2'd0; req_signed = 1'b0; resp_ready = 1'b1; mem_word = 64'd0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req_ready",  {63'd0, req_ready}, 64'd1);
      chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
      chk("rst_resp_rdata", resp_rdata, 64'd0);
      chk("rst_resp_err",   {63'd0, resp_err}, 64'd0);
      chk("rst_mem_valid",  {63'd0, mem_valid}, 64'd0);
      chk("rst_mem_wmask",  {56'd0, mem_wmask}, 64'd0);
      chk("rst_mem_wdata",  mem_wdata, 64'd0);
      chk("rst_mem_raddr",  mem_raddr, 64'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      // Store double.
      issue(1'b1, 64'h80000008, 64'h1122334455667788, SZ_D, 1'b0, 64'd0,
            1'b1, 8'hFF, 64'h1122334455667788, 1'b1, 2, 64'd0, 1'b0);
      wait_idle();
      // Store byte at lane 5.
      issue(1'b1, 64'h80000005, 64'h00000000000000AB, SZ_B, 1'b0, 64'd0,
            1'b1, 8'h20, 64'h0000AB0000000000, 1'b1, 2, 64'd0, 1'b0);
      wait_idle();
      // Load half, signed and unsigned.
      issue(1'b0, 64'h80000002, 64'd0, SZ_H, 1'b1, 64'h0000000080010000,
            1'b1, 8'h00, 64'd0, 1'b1, 3, 64'hFFFFFFFFFFFF8001, 1'b0);
      wait_idle();
      issue(1'b0, 64'h80000002, 64'd0, SZ_H, 1'b0, 64'h0000000080010000,
            1'b1, 8'h00, 64'd0, 1'b1, 3, 64'h0000000000008001, 1'b0);
      wait_idle();
      // Load word unsigned from upper half.
      issue(1'b0, 64'h80000004, 64'd0, SZ_W, 1'b0, 64'h89ABCDEF00000000,
            1'b1, 8'h00, 64'd0, 1'b1, 3, 64'h0000000089ABCDEF, 1'b0);
      wait_idle();
      // Misaligned word: error, no strobe.
      issue(1'b0, 64'h80000006, 64'd0, SZ_W, 1'b0, 64'hFFFFFFFFFFFFFFFF,
            1'b0, 8'h00, 64'd0, 1'b1, 1, 64'd0, 1'b1);
      wait_idle();

      // Response backpressure on a load double.
      resp_ready = 1'b0;
      issue(1'b0, 64'h80000010, 64'd0, SZ_D, 1'b0, 64'hDEADBEEFCAFEF00D,
            1'b1, 8'h00, 64'd0, 1'b1, 3, 64'hDEADBEEFCAFEF00D, 1'b0);
      repeat (7) begin
         @(posedge clk); #1;
      end
      chk("bp_resp_valid_held", {63'd0, resp_valid}, 64'd1);
      resp_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_req_ready_after", {63'd0, req_ready}, 64'd1);
      chk("bp_resp_valid_after", {63'd0, resp_valid}, 64'd0);
      wait_idle();

      // Reset during CAPT of a load drops it.
      issue(1'b0, 64'h80000000, 64'd0, SZ_D, 1'b0, 64'h0123456789ABCDEF,
            1'b1, 8'h00, 64'd0, 1'b0, 3, 64'd0, 1'b0);
      @(posedge clk); #2;
      reset = 1'b1;
      #1;
      chk("arst_mem_valid",  {63'd0, mem_valid}, 64'd0);
      chk("arst_resp_valid", {63'd0, resp_valid}, 64'd0);
      chk("arst_req_ready",  {63'd0, req_ready}, 64'd1);
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      chk("arst_no_resp", {63'd0, resp_valid}, 64'd0);
      // Next request after reset: load byte signed from lane 7.
      issue(1'b0, 64'h80000007, 64'd0, SZ_B, 1'b1, 64'h8000000000000000,
            1'b1, 8'h00, 64'd0, 1'b1, 3, 64'hFFFFFFFFFFFFFF80, 1'b0);
      wait_idle();

      repeat (2) @(posedge clk);
      #1;
      chk("mem_q_drained",  64'(mem_q.size()), 64'd0);
      chk("resp_q_drained", 64'(resp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/lsu_mem_bridge.md
# lsu_mem_bridge

Single-outstanding request bridge between the load/store unit and the DPI-C backed physical memory model. Accepts one aligned load or store per valid/ready handshake and drives the memory model's one-cycle valid/wen strobe with 8-byte-aligned addresses, byte lane masks and lane-shifted write data. Captures the registered read data and returns it to the LSU over a valid/ready response channel, sign- or zero-extended. Misaligned requests are rejected without touching memory.

## Interface
- XLEN, 64, data and address width; only 64 is supported.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  LSU request present.
- req_ready  out  1  bridge can accept a request; high only in IDLE.
- req_wen  in  1  1 = store, 0 = load.
- req_addr  in  XLEN  byte address.
- req_wdata  in  XLEN  store data, right-justified.
- req_size  in  2  access size: 0 = byte, 1 = half, 2 = word, 3 = double.
- req_signed  in  1  load result is sign-extended when 1, zero-extended when 0.
- resp_valid  out  1  response present.
- resp_ready  in  1  LSU accepts the response.
- resp_rdata  out  XLEN  extended load data; 0 for stores and errors.
- resp_err  out  1  request was misaligned.
- mem_valid  out  1  memory strobe; high for exactly one cycle per access.
- mem_wen  out  1  memory write enable.
- mem_raddr, mem_waddr  out  XLEN  request address with bits [2:0] cleared.
- mem_wdata  out  XLEN  write data shifted to its byte lanes.
- mem_wmask  out  8  byte lane mask; 0 for loads.
- mem_rdata  in  XLEN  memory read data, valid in the cycle after the strobe.

## Operation
- FSM states: IDLE, ISSUE, CAPT, RESP.
- IDLE: req_ready = 1. On req_valid, latch the request.
  - Aligned request: go to ISSUE.
  - Misaligned request (addr mod 2^size != 0): set the error flag and go to RESP.
- ISSUE: mem_valid = 1 and mem_wen = latched wen. Stores go to RESP; loads go to CAPT.
- CAPT: compute off = addr[2:0], take shifted = mem_rdata >> (8*off), keep the low 8/16/32/64 bits, extend to 64 bits by req_signed, and register the result. Go to RESP.
- RESP: resp_valid = 1. Hold resp_rdata and resp_err stable until resp_ready, then return to IDLE.
  - No new request is accepted in the same cycle as a response handshake.
- Store data shaping:
  - mem_wdata = req_wdata << (8*off).
  - mem_wmask = base << off, where base = 0x01, 0x03, 0x0F or 0xFF for size 0 to 3. The shift is truncated to 8 bits, which never happens for aligned requests.
- mem_* outputs are 0 in every state other than ISSUE. mem_wmask and mem_wdata are 0 for loads.
- A size-3 access always has off = 0, so no shift is applied.

## Timing
- Reset values: state = IDLE, req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0, all mem_* = 0.
- Reset is asynchronous. Asserting it mid-transaction drops the transaction, forces mem_valid low immediately, and returns to IDLE. The LSU must reissue.
- Load latency, with cycle 0 as the accept edge: ISSUE in cycle 1, CAPT in cycle 2, resp_valid in cycle 3.
- Store latency: ISSUE in cycle 1, resp_valid in cycle 2.
- Misaligned request: resp_valid in cycle 1, with no mem_valid pulse.
- Throughput: at best one load per 4 cycles and one store per 3 cycles, because IDLE is re-entered after every response.
- Response backpressure: the bridge stays in RESP indefinitely, with no further memory activity.
- mem_rdata is sampled only in CAPT, because the memory model zeroes it in later cycles.

## Structure
- Package lsu_mem_pkg contains:
  - state enum {IDLE, ISSUE, CAPT, RESP};
  - size localparams SZ_B, SZ_H, SZ_W, SZ_D;
  - a lane-mask base function;
  - XLEN.
- Sub-module lsu_mem_align: purely combinational. Produces mem_wdata and mem_wmask from (wdata, size, off), and the extended load data from (mem_rdata, size, off, signed). It is shared by the FSM top and reusable by the IFU path.

## Test plan
- Store double, addr 0x80000008, data 0x1122334455667788 -> one mem_valid pulse in cycle 1 with mem_wen = 1, waddr 0x80000008, wmask 0xFF, wdata unchanged; resp_valid in cycle 2 with resp_err = 0.
- Store byte, addr 0x80000005, data 0xAB -> waddr 0x80000000, wmask 0x20, wdata 0x0000AB0000000000.
- Load half, signed, addr 0x80000002, with memory returning 0x00000000_8001_0000 -> resp_rdata 0xFFFFFFFFFFFF8001. The same load with req_signed = 0 -> resp_rdata 0x0000000000008001. resp_valid in cycle 3.
- Load word, addr 0x80000006 (misaligned) -> no mem_valid pulse; resp_valid in cycle 1 with resp_err = 1 and resp_rdata 0.
- Hold resp_ready low for 5 cycles after a load -> resp_rdata stable, req_ready low and mem_valid low throughout; after resp_ready rises, IDLE is reached and req_ready = 1.
- Assert reset during CAPT of a load -> mem_valid and resp_valid 0 immediately and state IDLE; the next request completes normally.
